// File: rtl/serdes_cfg_tx.sv
// Serdes config TX: packs a frame of config bytes into 16-bit words and sends them as one burst.
// Optional feature SERDES_TX_CHKSUM_EN appends a mod-2^16 checksum word to every burst.
module serdes_cfg_tx #(
  parameter int FRAME_BYTES = 180,
  parameter int GAP_CYCLES  = 8
) (
  input  logic        I_serdes_tx_clk,
  input  logic        I_sys_rst,
  input  logic [7:0]  I_cfg_data,
  input  logic        I_cfg_en,
  input  logic        I_serdes_tx_rdy,
  output logic [15:0] O_serdes_tx_data,
  output logic        O_serdes_tx_en,
  output logic        O_busy,
  output logic        O_drop_err,
  output logic        O_frame_done
);

  localparam int N = FRAME_BYTES / 2;
`ifdef SERDES_TX_CHKSUM_EN
  localparam int BURST = N + 1;
`else
  localparam int BURST = N;
`endif
  localparam int CNT_W = $clog2(FRAME_BYTES + 3);
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] BURST_C   = CNT_W'(BURST);
  localparam logic [GW-1:0]    LAST_GAP  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SEND     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             v1_q, v1_d;
  logic             tx_en_q, tx_en_d;
  logic [15:0]      tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             done_q, done_d;
  logic [15:0]      mem_q [N];
  logic [15:0]      rd_word_q;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [15:0]      wr_word_s;
  logic             rd_en_s;
  logic [AW-1:0]    rd_addr_s;
`ifdef SERDES_TX_CHKSUM_EN
  logic [15:0]      sum_q, sum_d;
  logic             csel_q, csel_d;
`endif

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    rd_idx_d   = rd_idx_q;
    out_cnt_d  = out_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    v1_d       = 1'b0;
    tx_en_d    = 1'b0;
    tx_data_d  = 16'h0000;
    done_d     = 1'b0;
    drop_d     = I_cfg_en && (state_q != ST_COLLECT);
    wr_en_s    = 1'b0;
    wr_addr_s  = byte_cnt_q[AW:1];
    wr_word_s  = {hi_q, I_cfg_data};
    rd_en_s    = 1'b0;
    rd_addr_s  = rd_idx_q[AW-1:0];
`ifdef SERDES_TX_CHKSUM_EN
    sum_d      = sum_q;
    csel_d     = 1'b0;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (I_cfg_en) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q[0]) begin
            wr_en_s = 1'b1;
`ifdef SERDES_TX_CHKSUM_EN
            sum_d = sum_q + wr_word_s;
`endif
          end else begin
            hi_d = I_cfg_data;
          end
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_WAIT_RDY;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ST_WAIT_RDY: begin
        if (I_serdes_tx_rdy) begin
          state_d   = ST_SEND;
          rd_idx_d  = '0;
          out_cnt_d = '0;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_SEND: begin
        // Two-stage pipe: buffer read, then output register; no stall path exists.
        rd_en_s = (rd_idx_q < BURST_C);
        if (rd_en_s) begin
          rd_idx_d = rd_idx_q + CNT_W'(1);
          v1_d     = 1'b1;
`ifdef SERDES_TX_CHKSUM_EN
          csel_d   = (rd_idx_q == CNT_W'(N));
`endif
        end else begin
          rd_idx_d = rd_idx_q;
        end
        tx_en_d = v1_q;
`ifdef SERDES_TX_CHKSUM_EN
        tx_data_d = v1_q ? (csel_q ? sum_q : rd_word_q) : 16'h0000;
`else
        tx_data_d = v1_q ? rd_word_q : 16'h0000;
`endif
        if (tx_en_q) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
        end else begin
          out_cnt_d = out_cnt_q;
        end
        if (tx_en_q && (out_cnt_q == LAST_WORD)) begin
          state_d   = ST_GAP;
          done_d    = 1'b1;
          gap_cnt_d = '0;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d    = ST_COLLECT;
          byte_cnt_d = '0;
`ifdef SERDES_TX_CHKSUM_EN
          sum_d      = 16'h0000;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
    busy_d = (state_d != ST_COLLECT);
  end

  // Control and output registers
  always_ff @(posedge I_serdes_tx_clk) begin
    if (I_sys_rst) begin
      state_q    <= ST_COLLECT;
      byte_cnt_q <= '0;
      hi_q       <= 8'h00;
      rd_idx_q   <= '0;
      out_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      v1_q       <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 16'h0000;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SERDES_TX_CHKSUM_EN
      sum_q      <= 16'h0000;
      csel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hi_q       <= hi_d;
      rd_idx_q   <= rd_idx_d;
      out_cnt_q  <= out_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      v1_q       <= v1_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
`ifdef SERDES_TX_CHKSUM_EN
      sum_q      <= sum_d;
      csel_q     <= csel_d;
`endif
    end
  end

  // Word buffer: contents need no reset, read data is registered
  always_ff @(posedge I_serdes_tx_clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_word_s;
    end
    if (rd_en_s) begin
      rd_word_q <= mem_q[rd_addr_s];
    end
  end

  assign O_serdes_tx_data = tx_data_q;
  assign O_serdes_tx_en   = tx_en_q;
  assign O_busy           = busy_q;
  assign O_drop_err       = drop_q;
  assign O_frame_done     = done_q;

endmodule

// File: tb/tb_serdes_cfg_tx.sv
// Directed bench for serdes_cfg_tx: frame packing, ready wait, drops, mid-burst reset, back-to-back frames.
module tb_serdes_cfg_tx;

  localparam int FRAME_BYTES = 180;
  localparam int GAP_CYCLES  = 8;
  localparam int N           = FRAME_BYTES / 2;
`ifdef SERDES_TX_CHKSUM_EN
  localparam int BURST = N + 1;
`else
  localparam int BURST = N;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_data;
  logic        cfg_en;
  logic        rdy;
  logic [15:0] tx_data;
  logic        tx_en;
  logic        busy;
  logic        drop_err;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Monitor state
  logic [15:0] cap[$];
  int  run_len, last_len, bursts, nz, done_cnt, done_bad, drop_cnt;
  int  low_run, min_gap, gap_busy, last_gap_busy;
  bit  prev_en, ended, counting;

  serdes_cfg_tx #(.FRAME_BYTES(FRAME_BYTES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .I_serdes_tx_clk  (clk),
    .I_sys_rst        (rst),
    .I_cfg_data       (cfg_data),
    .I_cfg_en         (cfg_en),
    .I_serdes_tx_rdy  (rdy),
    .O_serdes_tx_data (tx_data),
    .O_serdes_tx_en   (tx_en),
    .O_busy           (busy),
    .O_drop_err       (drop_err),
    .O_frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_f(input int seed, input int i);
    logic [7:0] r;
    r = 8'(i + seed * 37);
    return r;
  endfunction

  function automatic logic [15:0] exp_word(input int seed, input int k);
    logic [15:0] s;
    s = 16'h0000;
    if (k < N) begin
      s = {byte_f(seed, 2 * k), byte_f(seed, 2 * k + 1)};
    end else begin
      for (int j = 0; j < N; j++) s = s + {byte_f(seed, 2 * j), byte_f(seed, 2 * j + 1)};
    end
    return s;
  endfunction

  function automatic int scan_frame(input int seed, input int off, output int idx,
                                    output logic [15:0] act, output logic [15:0] expv);
    int bad;
    logic [15:0] e;
    bad = 0; idx = -1; act = 16'h0000; expv = 16'h0000;
    for (int k = 0; k < BURST; k++) begin
      e = exp_word(seed, k);
      if (off + k >= cap.size()) begin
        bad++;
        if (idx < 0) begin idx = k; act = 16'h0000; expv = e; end
      end else if (cap[off + k] !== e) begin
        bad++;
        if (idx < 0) begin idx = k; act = cap[off + k]; expv = e; end
      end
    end
    return bad;
  endfunction

  // Monitor samples 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (!tx_en && prev_en) begin
      bursts++; last_len = run_len; run_len = 0;
      ended = 1'b1; low_run = 0; counting = 1'b1; gap_busy = 0;
    end
    if (tx_en && !prev_en && ended && (low_run < min_gap)) min_gap = low_run;
    if (tx_en) begin
      cap.push_back(tx_data);
      run_len++;
    end else begin
      low_run++;
      if (tx_data !== 16'h0000) nz++;
    end
    if (counting) begin
      if (busy === 1'b1) gap_busy++;
      else begin counting = 1'b0; last_gap_busy = gap_busy; end
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (!(prev_en && !tx_en)) done_bad++;
    end
    if (drop_err === 1'b1) drop_cnt++;
    prev_en = tx_en;
  end

  task automatic mon_clear();
    cap.delete();
    run_len = 0; last_len = 0; bursts = 0; nz = 0; done_cnt = 0; done_bad = 0;
    drop_cnt = 0; low_run = 0; min_gap = 1000000; gap_busy = 0; last_gap_busy = 0;
    prev_en = 1'b0; ended = 1'b0; counting = 1'b0;
  endtask

  task automatic send_frame(input int seed);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      cfg_data = byte_f(seed, i);
      cfg_en   = 1'b1;
      @(negedge clk);
    end
    cfg_en   = 1'b0;
    cfg_data = 8'h00;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_en = 1'b0; cfg_data = 8'h00; rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
    checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data: got %h expected 0000", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop_err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    bit ok; int bad, idx; logic [15:0] a, e;
    rdy = 1'b1;
    mon_clear();
    send_frame(0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_after_last: got %b expected 1", busy); end
    wait_done(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_done_timeout: got 0 done expected 1"); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_idle_timeout: busy stuck, expected 0"); end
    bad = scan_frame(0, 0, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t1_words: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
    checks++; if (last_len !== BURST) begin errors++; $display("FAIL t1_burst_len: got %0d expected %0d", last_len, BURST); end
    checks++; if (bursts !== 1) begin errors++; $display("FAIL t1_bursts: got %0d expected 1", bursts); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t1_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (done_bad !== 0) begin errors++; $display("FAIL t1_done_timing: got %0d misplaced expected 0", done_bad); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL t1_idle_data: got %0d nonzero expected 0", nz); end
    checks++; if (last_gap_busy !== GAP_CYCLES) begin errors++; $display("FAIL t1_gap_len: got %0d expected %0d", last_gap_busy, GAP_CYCLES); end
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL t1_drops: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_wait_rdy();
    bit ok; int bad, idx; logic [15:0] a, e;
    rdy = 1'b0;
    mon_clear();
    send_frame(1);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (tx_en !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t2_hold: got %0d bad cycles expected 0", bad); end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL t2_lat1: got %b expected 0", tx_en); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL t2_lat2: got %b expected 0", tx_en); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL t2_first_en: got %b expected 1", tx_en); end
    checks++; if (tx_data !== exp_word(1, 0)) begin errors++; $display("FAIL t2_first_word: got %h expected %h", tx_data, exp_word(1, 0)); end
    wait_done(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_done_timeout: got 0 done expected 1"); end
    wait_idle(ok);
    bad = scan_frame(1, 0, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t2_words: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
    checks++; if (last_len !== BURST) begin errors++; $display("FAIL t2_burst_len: got %0d expected %0d", last_len, BURST); end
    rdy = 1'b1;
  endtask

  task automatic test_drop();
    bit ok; int bad, idx; logic [15:0] a, e;
    rdy = 1'b1;
    mon_clear();
    send_frame(2);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tx_en === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL t3_burst_start: got no tx_en expected burst"); end
    for (int i = 0; i < 3; i++) begin
      cfg_en = 1'b1; cfg_data = 8'hA5;
      @(negedge clk);
    end
    cfg_en = 1'b0; cfg_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (drop_cnt !== 3) begin errors++; $display("FAIL t3_drop_cnt: got %0d expected 3", drop_cnt); end
    wait_done(1, ok);
    wait_idle(ok);
    send_frame(3);
    wait_done(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_done_timeout: got %0d done expected 2", done_cnt); end
    wait_idle(ok);
    bad = scan_frame(2, 0, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t3_words_a: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
    bad = scan_frame(3, BURST, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t3_words_b: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
  endtask

  task automatic test_reset_mid();
    bit ok; int bad, idx; logic [15:0] a, e;
    mon_clear();
    send_frame(4);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (cap.size() >= 40) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL t4_reach_word40: got %0d words expected 40", cap.size()); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL t4_tx_en: got %b expected 0", tx_en); end
    checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL t4_tx_data: got %h expected 0000", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL t4_done: got %b expected 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
    mon_clear();
    send_frame(5);
    wait_done(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_done_timeout: got 0 done expected 1"); end
    wait_idle(ok);
    bad = scan_frame(5, 0, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t4_words: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
    checks++; if (bursts !== 1 || last_len !== BURST) begin errors++; $display("FAIL t4_burst: got %0d bursts len %0d expected 1 len %0d", bursts, last_len, BURST); end
  endtask

  task automatic test_back_to_back();
    bit ok; int bad, idx, offered; logic [15:0] a, e;
    mon_clear();
    send_frame(6);
    offered = 0;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      cfg_en = 1'b1; cfg_data = 8'h5A;
      offered++;
      @(negedge clk);
    end
    cfg_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL t5_idle_timeout: busy stuck expected 0"); end
    send_frame(7);
    wait_done(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_done_timeout: got %0d done expected 2", done_cnt); end
    wait_idle(ok);
    checks++; if (offered <= GAP_CYCLES) begin errors++; $display("FAIL t5_offered: got %0d expected > %0d", offered, GAP_CYCLES); end
    checks++; if (drop_cnt !== offered) begin errors++; $display("FAIL t5_drop_cnt: got %0d expected %0d", drop_cnt, offered); end
    checks++; if (bursts !== 2) begin errors++; $display("FAIL t5_bursts: got %0d expected 2", bursts); end
    checks++; if (min_gap < GAP_CYCLES) begin errors++; $display("FAIL t5_min_gap: got %0d expected >= %0d", min_gap, GAP_CYCLES); end
    bad = scan_frame(6, 0, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t5_words_a: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
    bad = scan_frame(7, BURST, idx, a, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL t5_words_b: %0d bad, word %0d got %h expected %h", bad, idx, a, e); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL t5_idle_data: got %0d nonzero expected 0", nz); end
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_data = 8'h00; rdy = 1'b0;
    mon_clear();
    test_reset();
    test_single_frame();
    test_wait_rdy();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
